// File: rtl/kmeans_regfile_pkg.sv
// Shared definitions for the k-means register file and its host-side APB master:
// register map, default widths and the master FSM state type.
package kmeans_regfile_pkg;

    localparam int unsigned DefaultAddrWidth = 9;
    localparam int unsigned DefaultDataWidth = 91;
    localparam int unsigned DefaultTimeout   = 16;

    localparam logic [8:0] RegStatus       = 9'd0;
    localparam logic [8:0] RegGo           = 9'd1;
    localparam logic [8:0] RegCent1        = 9'd2;
    localparam logic [8:0] RegCent2        = 9'd3;
    localparam logic [8:0] RegCent3        = 9'd4;
    localparam logic [8:0] RegCent4        = 9'd5;
    localparam logic [8:0] RegCent5        = 9'd6;
    localparam logic [8:0] RegCent6        = 9'd7;
    localparam logic [8:0] RegCent7        = 9'd8;
    localparam logic [8:0] RegCent8        = 9'd9;
    localparam logic [8:0] RegRamAddr      = 9'd10;
    localparam logic [8:0] RegRamData      = 9'd11;
    localparam logic [8:0] RegFirstRamAddr = 9'd12;
    localparam logic [8:0] RegLastRamAddr  = 9'd13;
    localparam logic [8:0] RegThreshold    = 9'd14;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } master_state_e;

endpackage

// File: rtl/apb_host_master_if.sv
// Command/response channels and APB bus of the host-side APB master.
// The master modport is the APB initiator; the slave modport is the host and register file side.
interface apb_host_master_if
    import kmeans_regfile_pkg::*;
#(
    parameter int unsigned addrWidth = DefaultAddrWidth,
    parameter int unsigned dataWidth = DefaultDataWidth
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 busy;

    logic [addrWidth-1:0] paddr;
    logic                 pwrite;
    logic                 psel;
    logic                 penable;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  paddr, pwrite, psel, penable, pwdata
    );

endinterface

// File: rtl/apb_host_master.sv
// Single-outstanding APB initiator: accepts one register command, runs SETUP/ACCESS,
// and returns read data or a timeout error on the response channel.
module apb_host_master
    import kmeans_regfile_pkg::*;
#(
    parameter int unsigned addrWidth = DefaultAddrWidth,
    parameter int unsigned dataWidth = DefaultDataWidth,
    parameter int unsigned TIMEOUT   = DefaultTimeout
) (
    input  logic                    clk,
    input  logic                    rst_n,
    apb_host_master_if.master       bus
);

    localparam int unsigned CntW    = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    master_state_e        state_q;
    logic [CntW-1:0]      cnt_q;
    logic [addrWidth-1:0] paddr_q;
    logic                 pwrite_q;
    logic                 psel_q;
    logic                 penable_q;
    logic [dataWidth-1:0] pwdata_q;
    logic                 rsp_valid_q;
    logic [dataWidth-1:0] rsp_rdata_q;
    logic                 rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        paddr_q   <= bus.cmd_addr;
                        pwrite_q  <= bus.cmd_write;
                        pwdata_q  <= bus.cmd_write ? bus.cmd_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    // pready takes priority over a timeout landing in the same cycle
                    if (bus.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q == LastCnt) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_host_master.md
Name: apb_host_master

Overview:
APB master (initiator) for the k-means register file's host-side APB port. It takes single register read/write commands over a valid/ready command channel and runs the APB SETUP/ACCESS phases. It waits for pready, or gives up after a bounded timeout. It returns read data and an error flag over a valid/ready response channel. It sits between the host/stub sequencer and the register file, and allows one outstanding transfer at a time.

Parameters:
addrWidth, 9, width of paddr/cmd_addr
dataWidth, 91, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, max ACCESS-phase cycles without pready before error (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_write  input  1  1=write, 0=read
cmd_addr  input  addrWidth  register address
cmd_wdata  input  dataWidth  write data (ignored on read)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when high with rsp_valid
rsp_rdata  output  dataWidth  read data (0 on writes and on errors)
rsp_err  output  1  1 = timeout, no pready seen
busy  output  1  high in any state other than IDLE
paddr  output  addrWidth  APB address
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB enable
pwdata  output  dataWidth  APB write data
prdata  input  dataWidth  APB read data
pready  input  1  APB completion

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state is registered.
- Reset values:
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
  - cmd_ready = (state==IDLE), so it reads 1 during and after reset; busy reads 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register paddr=cmd_addr, pwrite=cmd_write, pwdata = cmd_write ? cmd_wdata : 0; set psel=1, penable=0; go to SETUP.
- SETUP (exactly 1 cycle):
  - Next cycle penable=1, psel stays 1, counter cleared to 0.
  - Go to ACCESS.
- ACCESS:
  - paddr, pwrite and pwdata are held stable for the whole phase.
  - Each cycle pready is sampled.
    - pready=1: psel=penable=0; rsp_rdata = pwrite ? 0 : prdata; rsp_err=0; rsp_valid=1; go to RESP.
    - pready=0 and counter==TIMEOUT-1: psel=penable=0; rsp_rdata=0; rsp_err=1; rsp_valid=1; go to RESP.
    - Otherwise: counter+1.
  - pready and the timeout hitting in the same cycle: pready wins (normal completion).
  - Counter width is $clog2(TIMEOUT). Wrap is not reachable.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On that cycle: rsp_valid=0; go to IDLE.
  - APB outputs stay idle; paddr/pwdata keep their last value.
- Latency:
  - Command accept to first psel is 1 cycle.
  - Zero-wait slave (pready 1 cycle after penable rises): accept to rsp_valid is 3 cycles.
  - Back-to-back commands: at least 2 idle APB cycles between transfers (RESP + IDLE). This gives the register file's one-cycle pready pulse time to clear.
- Protocol rules:
  - pready outside ACCESS is ignored.
  - A register file holding off APB while its GO is set never asserts pready, so the transfer ends as a timeout error. Upper layers retry after interrupt.
  - cmd_* is ignored when cmd_ready=0.
- Reset mid-transfer: the transfer is aborted, psel/penable drop asynchronously, and the pending command and response are discarded.

Decomposition:
- Shared package kmeans_regfile_pkg, used by both this block and the register file:
  - register address constants: STATUS=0, GO=1, CENT_1..CENT_8=2..9, RAM_ADDR=10, RAM_DATA=11, FIRST_RAM_ADDR=12, LAST_RAM_ADDR=13, THRESHOLD=14;
  - master FSM state enum (2 bits);
  - default widths 9/91/16.
- No sub-module: FSM, timeout counter and output registers fit in one module.

Test Plan:
- Write: cmd addr=14, wdata=0x1234, zero-wait slave -> psel high 2 cycles, penable high 1 cycle, pwdata=0x1234 held; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read: cmd addr=4 (CENT_3), slave returns prdata=91'h5A5 with 3 wait states -> ACCESS lasts 4 cycles, paddr stable, rsp_rdata=0x5A5, rsp_err=0.
- Timeout: TIMEOUT=16, pready tied 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_rdata=0. Variant: pready rises on cycle 16 -> rsp_err=0.
- Back-pressure and back-to-back: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, no psel. Then write addr 10 data 0x20 followed by addr 11 data 0xAB -> two transfers in order, with at least 2 idle cycles between them.
- Reset: assert rst_n=0 during ACCESS of a read -> psel/penable/rsp_valid go 0 immediately, cmd_ready=1 after release, no stale response.
